// File: rtl/mac_pkg.sv
// mac_pkg: shared state type and framing/CRC constants
// for the MAC receive path.
package mac_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_DATA,
    S_TRUNC,
    S_DROP
  } rx_state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;

endpackage

// File: rtl/mac_crc32_d8.sv
// mac_crc32_d8: combinational CRC32 (reflected, LSB first)
// next-state for one data byte.
module mac_crc32_d8
  import mac_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] next_crc
);

  logic [31:0] c;

  always_comb begin
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i])
        c = (c >> 1) ^ CRC_POLY;
      else
        c = c >> 1;
    end
    next_crc = c;
  end

endmodule

// File: rtl/mac_rx_frame.sv
// mac_rx_frame: strips preamble/SFD/FCS, flags bad frames, counts.
// CRC32 check is built only when MAC_RX_CRC_CHECK_EN is defined.
module mac_rx_frame
  import mac_pkg::*;
#(
  parameter int MIN_FRAME_LEN = 64,
  parameter int MAX_FRAME_LEN = 1518
) (
  input  logic        sys_clk,
  input  logic        sys_rstn,
  input  logic [7:0]  phy_rxd_in,
  input  logic        phy_rvalid_in,
  output logic        phy_rready_out,
  input  logic        phy_rerr_in,
  output logic [7:0]  mac_rdata_out,
  output logic        mac_rvalid_out,
  input  logic        mac_rready_in,
  output logic        mac_rlast_out,
  output logic        mac_ruser_out,
  output logic [15:0] good_cnt_out,
  output logic [15:0] bad_cnt_out
);

  rx_state_t state_q, state_d;

  logic            rdy_q;
  logic [4:0][7:0] dl_q;
  logic [15:0]     cnt_q;
  logic            bad_q;
  logic            pend_q;
  logic [7:0]      pend_data_q;
  logic            pend_user_q;

  logic start, push, emit, emit_last, last_user;
  logic inc_good, inc_bad;
  logic full, runt, crc_bad, frame_bad, free;

  assign full      = cnt_q >= 16'd5;
  assign runt      = cnt_q < 16'(MIN_FRAME_LEN);
  assign frame_bad = bad_q | runt | crc_bad;
  assign free      = ~mac_rvalid_out | mac_rready_in;

  assign phy_rready_out = rdy_q;

`ifdef MAC_RX_CRC_CHECK_EN
  logic [31:0] crc_q, crc_d;

  mac_crc32_d8 u_crc (
    .crc      (crc_q),
    .data     (phy_rxd_in),
    .next_crc (crc_d)
  );

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn)
      crc_q <= CRC_INIT;
    else if (start)
      crc_q <= CRC_INIT;
    else if (push)
      crc_q <= crc_d;
  end

  assign crc_bad = crc_q != CRC_RESIDUE;
`else
  assign crc_bad = 1'b0;
`endif

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    push      = 1'b0;
    emit      = 1'b0;
    emit_last = 1'b0;
    last_user = 1'b1;
    inc_good  = 1'b0;
    inc_bad   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // first cycle out of reset may land mid-frame
        if (phy_rvalid_in)
          state_d = (rdy_q && phy_rxd_in == PREAMBLE_BYTE)
                  ? S_PREAMBLE : S_DROP;
      end
      S_PREAMBLE: begin
        if (!phy_rvalid_in) begin
          state_d = S_IDLE;
        end else if (phy_rxd_in == SFD_BYTE) begin
          if (pend_q) begin
            state_d = S_DROP;
            inc_bad = 1'b1;
          end else begin
            state_d = S_DATA;
            start   = 1'b1;
          end
        end else if (phy_rxd_in != PREAMBLE_BYTE) begin
          state_d = S_DROP;
        end
      end
      S_DATA: begin
        if (!phy_rvalid_in) begin
          state_d = S_IDLE;
          if (full) begin
            emit_last = 1'b1;
            last_user = frame_bad;
            inc_good  = ~frame_bad;
            inc_bad   = frame_bad;
          end else begin
            inc_bad = 1'b1;
          end
        end else if (cnt_q == 16'(MAX_FRAME_LEN)) begin
          state_d = S_TRUNC;
        end else begin
          push = 1'b1;
          emit = full;
        end
      end
      S_TRUNC: begin
        state_d   = S_DROP;
        emit_last = 1'b1;
        inc_bad   = 1'b1;
      end
      S_DROP: begin
        if (!phy_rvalid_in)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      rdy_q <= 1'b0;
      dl_q  <= '0;
      cnt_q <= '0;
      bad_q <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (start)
        cnt_q <= '0;
      else if (push) begin
        cnt_q <= cnt_q + 16'd1;
        dl_q  <= {dl_q[3:0], phy_rxd_in};
      end
      if (start)
        bad_q <= 1'b0;
      else if ((push && phy_rerr_in) || (emit && !free))
        bad_q <= 1'b1;
    end
  end

  // single output register; a blocked end-of-frame beat waits in pend_q
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      mac_rvalid_out <= 1'b0;
      mac_rdata_out  <= '0;
      mac_rlast_out  <= 1'b0;
      mac_ruser_out  <= 1'b0;
      pend_q         <= 1'b0;
      pend_data_q    <= '0;
      pend_user_q    <= 1'b0;
    end else if (free) begin
      if (pend_q) begin
        mac_rvalid_out <= 1'b1;
        mac_rdata_out  <= pend_data_q;
        mac_rlast_out  <= 1'b1;
        mac_ruser_out  <= pend_user_q;
        pend_q         <= 1'b0;
      end else if (emit || emit_last) begin
        mac_rvalid_out <= 1'b1;
        mac_rdata_out  <= dl_q[4];
        mac_rlast_out  <= emit_last;
        mac_ruser_out  <= emit_last & last_user;
      end else begin
        mac_rvalid_out <= 1'b0;
        mac_rlast_out  <= 1'b0;
        mac_ruser_out  <= 1'b0;
      end
    end else if (emit_last) begin
      pend_q      <= 1'b1;
      pend_data_q <= dl_q[4];
      pend_user_q <= last_user;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      good_cnt_out <= '0;
      bad_cnt_out  <= '0;
    end else begin
      if (inc_good)
        good_cnt_out <= good_cnt_out + 16'd1;
      if (inc_bad)
        bad_cnt_out <= bad_cnt_out + 16'd1;
    end
  end

endmodule

// File: tb/tb_mac_rx_frame.sv
// tb_mac_rx_frame: directed and random frames checked against
// a frame-level reference model.
`timescale 1ns/1ps
module tb_mac_rx_frame;

  localparam int MINL = 64;
  localparam int MAXL = 1518;
`ifdef MAC_RX_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  rxd = '0;
  logic        valid = 1'b0;
  logic        rerr = 1'b0;
  logic        rready = 1'b1;
  logic        phy_rready;
  logic [7:0]  rdata;
  logic        rvalid, rlast, ruser;
  logic [15:0] good_cnt, bad_cnt;

  mac_rx_frame #(.MIN_FRAME_LEN(MINL), .MAX_FRAME_LEN(MAXL)) dut (
    .sys_clk        (clk),
    .sys_rstn       (rstn),
    .phy_rxd_in     (rxd),
    .phy_rvalid_in  (valid),
    .phy_rready_out (phy_rready),
    .phy_rerr_in    (rerr),
    .mac_rdata_out  (rdata),
    .mac_rvalid_out (rvalid),
    .mac_rready_in  (rready),
    .mac_rlast_out  (rlast),
    .mac_ruser_out  (ruser),
    .good_cnt_out   (good_cnt),
    .bad_cnt_out    (bad_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int ncmp = 0;
  int nfail = 0;
  int exp_good = 0;
  int exp_bad = 0;
  int t_b5 = 0;
  int t_end = 0;

  logic [7:0] body[$];
  logic [7:0] got_d[$];
  bit         got_l[$];
  bit         got_u[$];
  int         got_c[$];
  logic [7:0] exp_d[$];
  bit         exp_l[$];
  bit         exp_u[$];

  // inputs and outputs are stable across the negedge
  always @(negedge clk) begin
    if (rstn && rvalid && rready) begin
      got_d.push_back(rdata);
      got_l.push_back(rlast);
      got_u.push_back(ruser);
      got_c.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc32_of(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int k = 0; k < n; k++) begin
      c = c ^ {24'd0, body[k]};
      repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  task automatic build_body(input int n, input bit corrupt);
    logic [31:0] fcs;
    body.delete();
    if (n < 4) begin
      for (int k = 0; k < n; k++) body.push_back(8'($urandom));
    end else begin
      for (int k = 0; k < n - 4; k++) body.push_back(8'($urandom));
      fcs = ~crc32_of(n - 4);
      for (int k = 0; k < 4; k++) body.push_back(fcs[8*k +: 8]);
      if (corrupt) body[n-4][0] = ~body[n-4][0];
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input bit l, input bit u);
    exp_d.push_back(d);
    exp_l.push_back(l);
    exp_u.push_back(u);
  endtask

  task automatic model(input bit had_err, input bit corrupt);
    int n;
    int nout;
    bit bad;
    n = body.size();
    if (n < 5) begin
      exp_bad++;
      return;
    end
    if (n > MAXL) begin
      nout = MAXL - 4;
      bad = 1'b1;
    end else begin
      nout = n - 4;
      bad = had_err || n < MINL || (CRC_EN && corrupt);
    end
    for (int k = 0; k < nout; k++)
      push_exp(body[k], k == nout - 1, (k == nout - 1) && bad);
    if (bad) exp_bad++;
    else exp_good++;
  endtask

  // stream: 7x55, D5, body, then gap idle cycles; rready low in [ss, ss+sl)
  task automatic send(input int err_idx, input int ss, input int sl,
                      input int gap, input int cut);
    int total;
    total = 8 + body.size();
    for (int i = 0; i < total + gap; i++) begin
      if (cut >= 0 && i == cut) break;
      @(posedge clk);
      #1;
      rready = !(i >= ss && i < ss + sl);
      if (i < total) begin
        valid = 1'b1;
        rxd = (i < 7) ? 8'h55 : (i == 7) ? 8'hD5 : body[i-8];
        rerr = (i - 8 == err_idx);
        if (i == 13) t_b5 = cyc;
      end else begin
        valid = 1'b0;
        rxd = 8'h00;
        rerr = 1'b0;
        if (i == total) t_end = cyc;
      end
    end
  endtask

  task automatic settle();
    repeat (30) @(posedge clk);
    #1;
  endtask

  task automatic clear_got();
    got_d.delete();
    got_l.delete();
    got_u.delete();
    got_c.delete();
  endtask

  task automatic check_out(input string tag);
    int n;
    chk({tag, "_beats"}, 32'(got_d.size()), 32'(exp_d.size()));
    n = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
    for (int k = 0; k < n; k++)
      chk($sformatf("%s_b%0d", tag, k),
          32'({got_l[k], got_l[k] & got_u[k], got_d[k]}),
          32'({exp_l[k], exp_l[k] & exp_u[k], exp_d[k]}));
    chk({tag, "_good"}, 32'(good_cnt), 32'(exp_good % 65536));
    chk({tag, "_bad"}, 32'(bad_cnt), 32'(exp_bad % 65536));
    clear_got();
    exp_d.delete();
    exp_l.delete();
    exp_u.delete();
  endtask

  initial begin
    int nl;
    int n;
    int ri;
    bit cor;

    // reset values, with the PHY already mid-preamble
    rstn = 1'b0;
    valid = 1'b1;
    rxd = 8'h55;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rready", 32'(phy_rready), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_rlast", 32'(rlast), 0);
    chk("rst_ruser", 32'(ruser), 0);
    chk("rst_good", 32'(good_cnt), 0);
    chk("rst_bad", 32'(bad_cnt), 0);

    // release while a frame is in flight: must be dropped silently
    build_body(64, 1'b0);
    rstn = 1'b1;
    send(-1, -1, 0, 4, -1);
    settle();
    chk("rstrel_rready", 32'(phy_rready), 1);
    check_out("rstrel");

    // reset asserted mid-frame: no last beat, counters untouched
    build_body(64, 1'b0);
    send(-1, -1, 0, 0, 38);
    @(posedge clk);
    #1;
    valid = 1'b0;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mrst_rvalid", 32'(rvalid), 0);
    rstn = 1'b1;
    settle();
    nl = 0;
    foreach (got_l[k]) nl += int'(got_l[k]);
    chk("mrst_nlast", 32'(nl), 0);
    clear_got();
    check_out("mrst");

    // good 64-byte frame, with latency checks
    build_body(64, 1'b0);
    send(-1, -1, 0, 4, -1);
    model(1'b0, 1'b0);
    settle();
    if (got_c.size() > 0) begin
      chk("good_lat_first", 32'(got_c[0]), 32'(t_b5 + 1));
      chk("good_lat_last", 32'(got_c[got_c.size()-1]), 32'(t_end + 1));
    end
    check_out("good");

    // FCS bit 0 flipped
    build_body(64, 1'b1);
    send(-1, -1, 0, 4, -1);
    model(1'b0, 1'b1);
    settle();
    check_out("badfcs");

    // PHY error on payload byte 20
    build_body(64, 1'b0);
    send(20, -1, 0, 4, -1);
    model(1'b1, 1'b0);
    settle();
    check_out("rerr");

    // runt with correct FCS
    build_body(40, 1'b0);
    send(-1, -1, 0, 4, -1);
    model(1'b0, 1'b0);
    settle();
    check_out("runt");

    // oversize frame
    build_body(1600, 1'b0);
    send(-1, -1, 0, 4, -1);
    model(1'b0, 1'b0);
    settle();
    check_out("over");

    // boundaries: exactly max, and max+1
    build_body(MAXL, 1'b0);
    send(-1, -1, 0, 4, -1);
    model(1'b0, 1'b0);
    build_body(MAXL + 1, 1'b0);
    send(-1, -1, 0, 4, -1);
    model(1'b0, 1'b0);
    settle();
    check_out("maxb");

    // backpressure for 2 cycles mid-payload: those due bytes are lost
    build_body(64, 1'b0);
    send(-1, 38, 2, 4, -1);
    for (int k = 0; k < 60; k++)
      if (!(k >= 38 - 13 && k < 38 - 13 + 2))
        push_exp(body[k], k == 59, k == 59);
    exp_bad++;
    build_body(64, 1'b0);
    send(-1, -1, 0, 4, -1);
    model(1'b0, 1'b0);
    settle();
    check_out("stall");

    // last beat held by backpressure; next SFD arrives meanwhile
    build_body(64, 1'b0);
    n = body.size() + 8;
    send(-1, n, 1, 1, -1);
    model(1'b0, 1'b0);
    build_body(64, 1'b0);
    send(-1, 0, n, 4, -1);
    exp_bad++;
    settle();
    check_out("pend");

    // random frames
    for (int f = 0; f < 10; f++) begin
      n = $urandom_range(1, 120);
      cor = 1'($urandom_range(0, 1));
      ri = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      build_body(n, cor);
      send(ri, -1, 0, $urandom_range(1, 4), -1);
      model(ri >= 0, cor);
    end
    settle();
    check_out("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
